// File: rtl/intwb_btb_update_arb.sv
// BTB SRAM port arbiter: frontend prediction reads vs. queued BTB update writes
// coming from the integer writeback stage. Updates are buffered in an in-order
// FIFO and drained on idle read cycles, or forced in when the FIFO is full or
// the head entry has lost arbitration for too long.
module intwb_btb_update_arb #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int IDX_W        = 9,
    parameter int DATA_W       = 129
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       intwb_bjusb_btb_ce,
    input  logic                       intwb_bjusb_btb_we,
    input  logic [DATA_W-1:0]          intwb_bjusb_btb_wmask,
    input  logic [IDX_W-1:0]           intwb_bjusb_btb_write_index,
    input  logic [DATA_W-1:0]          intwb_bjusb_btb_din,
    input  logic                       fe_btb_rd_req,
    input  logic [IDX_W-1:0]           fe_btb_rd_index,
    output logic                       fe_btb_rd_grant,
    output logic                       btb_ce,
    output logic                       btb_we,
    output logic [DATA_W-1:0]          btb_wmask,
    output logic [IDX_W-1:0]           btb_index,
    output logic [DATA_W-1:0]          btb_din,
    output logic                       upd_pending,
    output logic [$clog2(DEPTH+1)-1:0] upd_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [IDX_W-1:0]  fifo_index [DEPTH];
    logic [DATA_W-1:0] fifo_mask  [DEPTH];
    logic [DATA_W-1:0] fifo_data  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       starve_cnt;

    logic push;
    logic pop;
    logic not_empty;
    logic full;
    logic starved;
    logic write_sel;

    assign push      = intwb_bjusb_btb_ce && intwb_bjusb_btb_we;
    assign not_empty = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign starved   = (starve_cnt >= 8'(STARVE_LIMIT));
    // A full FIFO always wins the port, so a push at full is matched by a pop
    // and no update is ever dropped.
    assign write_sel = not_empty && (!fe_btb_rd_req || full || starved);
    assign pop       = write_sel;

    assign fe_btb_rd_grant = fe_btb_rd_req && !write_sel;
    assign upd_pending     = not_empty;
    assign upd_count       = count;

    // Steer the single SRAM port to the FIFO head, the frontend read, or idle.
    always_comb begin
        btb_ce    = 1'b0;
        btb_we    = 1'b0;
        btb_index = '0;
        btb_wmask = '0;
        btb_din   = '0;
        if (write_sel) begin
            btb_ce    = 1'b1;
            btb_we    = 1'b1;
            btb_index = fifo_index[rd_ptr];
            btb_wmask = fifo_mask[rd_ptr];
            btb_din   = fifo_data[rd_ptr];
        end else if (fe_btb_rd_req) begin
            btb_ce    = 1'b1;
            btb_index = fe_btb_rd_index;
        end
    end

    // FIFO storage needs no reset; only the pointers/count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_index[wr_ptr] <= intwb_bjusb_btb_write_index;
            fifo_mask[wr_ptr]  <= intwb_bjusb_btb_wmask;
            fifo_data[wr_ptr]  <= intwb_bjusb_btb_din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Count consecutive cycles the head entry lost to a frontend read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!not_empty || write_sel) begin
            starve_cnt <= '0;
        end else if (fe_btb_rd_req && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // An accepted push at full must always be paired with a pop.
    push_at_full_without_pop : assert property (
        @(posedge clock) disable iff (!reset_n) !(push && full && !pop)
    );

endmodule

// File: tb/tb_intwb_btb_update_arb.sv
// Directed bench for intwb_btb_update_arb with default parameters.
module tb_intwb_btb_update_arb;

    localparam int IDX_W  = 9;
    localparam int DATA_W = 129;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              upd_ce = 1'b0;
    logic              upd_we = 1'b0;
    logic [DATA_W-1:0] upd_mask = '0;
    logic [IDX_W-1:0]  upd_index = '0;
    logic [DATA_W-1:0] upd_din = '0;
    logic              rd_req = 1'b0;
    logic [IDX_W-1:0]  rd_index = '0;
    logic              rd_grant;
    logic              btb_ce;
    logic              btb_we;
    logic [DATA_W-1:0] btb_wmask;
    logic [IDX_W-1:0]  btb_index;
    logic [DATA_W-1:0] btb_din;
    logic              upd_pending;
    logic [2:0]        upd_count;

    int compared = 0;
    int mismatched = 0;

    intwb_btb_update_arb dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .intwb_bjusb_btb_ce          (upd_ce),
        .intwb_bjusb_btb_we          (upd_we),
        .intwb_bjusb_btb_wmask       (upd_mask),
        .intwb_bjusb_btb_write_index (upd_index),
        .intwb_bjusb_btb_din         (upd_din),
        .fe_btb_rd_req               (rd_req),
        .fe_btb_rd_index             (rd_index),
        .fe_btb_rd_grant             (rd_grant),
        .btb_ce                      (btb_ce),
        .btb_we                      (btb_we),
        .btb_wmask                   (btb_wmask),
        .btb_index                   (btb_index),
        .btb_din                     (btb_din),
        .upd_pending                 (upd_pending),
        .upd_count                   (upd_count)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [191:0] observed, input logic [191:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge, then let them settle.
    task automatic apply_stimulus(input logic req, input logic [IDX_W-1:0] ridx,
                                  input logic ce, input logic we,
                                  input logic [IDX_W-1:0] widx, input logic [DATA_W-1:0] din);
        rd_req    = req;
        rd_index  = ridx;
        upd_ce    = ce;
        upd_we    = we;
        upd_index = widx;
        upd_din   = din;
        upd_mask  = {DATA_W{1'b1}};
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [IDX_W-1:0] order [6];

        // Reset with everything idle
        #1 reset_n = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("reset_count", upd_count, 3'd0);
        check_output("reset_pending", upd_pending, 1'b0);
        check_output("reset_ce", btb_ce, 1'b0);
        check_output("reset_we", btb_we, 1'b0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;

        // Plain read gets the port in the same cycle
        apply_stimulus(1'b1, 9'h033, 1'b0, 1'b0, '0, '0);
        check_output("rd_ce", btb_ce, 1'b1);
        check_output("rd_we", btb_we, 1'b0);
        check_output("rd_index", btb_index, 9'h033);
        check_output("rd_grant", rd_grant, 1'b1);
        check_output("rd_wmask", btb_wmask, '0);
        next_cycle();

        // ce without we is ignored
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 9'h0FF, 129'h77);
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("ce_only_count", upd_count, 3'd0);
        check_output("ce_only_ce", btb_ce, 1'b0);
        next_cycle();

        // Single push, written on the following cycle
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 9'h1A5, 129'h1_DEAD_BEEF);
        check_output("push_no_bypass_ce", btb_ce, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("push_n1_count", upd_count, 3'd1);
        check_output("push_n1_we", btb_we, 1'b1);
        check_output("push_n1_index", btb_index, 9'h1A5);
        check_output("push_n1_din", btb_din, 129'h1_DEAD_BEEF);
        check_output("push_n1_wmask", btb_wmask, {DATA_W{1'b1}});
        next_cycle();
        check_output("push_n2_count", upd_count, 3'd0);
        check_output("push_n2_ce", btb_ce, 1'b0);
        next_cycle();

        // Starvation: one queued entry under continuous reads
        apply_stimulus(1'b1, 9'h011, 1'b1, 1'b1, 9'h0AA, 129'h5);
        check_output("starve_push_grant", rd_grant, 1'b1);
        next_cycle();
        apply_stimulus(1'b1, 9'h011, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("starve_grant_%0d", i), rd_grant, 1'b1);
            check_output($sformatf("starve_we_%0d", i), btb_we, 1'b0);
            next_cycle();
            #2;
        end
        check_output("starve_forced_grant", rd_grant, 1'b0);
        check_output("starve_forced_we", btb_we, 1'b1);
        check_output("starve_forced_index", btb_index, 9'h0AA);
        next_cycle();
        #2;
        check_output("starve_after_grant", rd_grant, 1'b1);
        check_output("starve_after_count", upd_count, 3'd0);
        next_cycle();

        // Fill to full under reads; pushes 5 and 6 force writes
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(1'b1, 9'h055, 1'b1, 1'b1, IDX_W'(i), 129'(i) + 129'h1000);
            if (i >= 5) begin
                check_output($sformatf("full_count_p%0d", i), upd_count, 3'd4);
                check_output($sformatf("full_we_p%0d", i), btb_we, 1'b1);
                check_output($sformatf("full_grant_p%0d", i), rd_grant, 1'b0);
                check_output($sformatf("full_index_p%0d", i), btb_index, 9'(i - 4));
            end else begin
                check_output($sformatf("fill_grant_p%0d", i), rd_grant, 1'b1);
            end
            next_cycle();
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("full_hold_count", upd_count, 3'd4);
        order = '{9'h003, 9'h004, 9'h005, 9'h006, 9'h000, 9'h000};
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("drain_we_%0d", i), btb_we, 1'b1);
            check_output($sformatf("drain_index_%0d", i), btb_index, order[i]);
            check_output($sformatf("drain_din_%0d", i), btb_din, 129'(order[i]) + 129'h1000);
            next_cycle();
            #2;
        end
        check_output("drain_done_count", upd_count, 3'd0);
        next_cycle();

        // Push and pop together at count 2
        apply_stimulus(1'b1, 9'h022, 1'b1, 1'b1, 9'h0B1, 129'hB1);
        next_cycle();
        apply_stimulus(1'b1, 9'h022, 1'b1, 1'b1, 9'h0B2, 129'hB2);
        check_output("pp_setup_grant", rd_grant, 1'b1);
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 9'h0B3, 129'hB3);
        check_output("pp_count_before", upd_count, 3'd2);
        check_output("pp_we", btb_we, 1'b1);
        check_output("pp_index_b1", btb_index, 9'h0B1);
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("pp_count_after", upd_count, 3'd2);
        check_output("pp_index_b2", btb_index, 9'h0B2);
        next_cycle();
        #2;
        check_output("pp_count_last", upd_count, 3'd1);
        check_output("pp_index_b3", btb_index, 9'h0B3);
        check_output("pp_din_b3", btb_din, 129'hB3);
        next_cycle();

        // Back-to-back streaming to exercise pointer wrap several more times
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                apply_stimulus(1'b0, '0, 1'b1, 1'b1, 9'h100 + 9'(i), 129'h200 + 129'(i));
            end else begin
                apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
            end
            if (i > 0) begin
                check_output($sformatf("wrap_count_%0d", i), upd_count, 3'd1);
                check_output($sformatf("wrap_index_%0d", i), btb_index, 9'h100 + 9'(i - 1));
                check_output($sformatf("wrap_din_%0d", i), btb_din, 129'h200 + 129'(i - 1));
            end
            next_cycle();
        end

        // Reset mid-operation with three queued entries
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 9'h044, 1'b1, 1'b1, 9'h0C1 + 9'(i), 129'hC0 + 129'(i));
            next_cycle();
        end
        apply_stimulus(1'b1, 9'h044, 1'b0, 1'b0, '0, '0);
        check_output("rst_mid_count_before", upd_count, 3'd3);
        reset_n = 1'b0;
        #1;
        check_output("rst_mid_count", upd_count, 3'd0);
        check_output("rst_mid_pending", upd_pending, 1'b0);
        check_output("rst_mid_we", btb_we, 1'b0);
        check_output("rst_mid_ce", btb_ce, 1'b1);
        check_output("rst_mid_index", btb_index, 9'h044);
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("rst_hold_we", btb_we, 1'b0);
        reset_n = 1'b1;
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 9'h1C3, 129'hABC);
        check_output("rst_after_push_ce", btb_ce, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_output("rst_after_count", upd_count, 3'd1);
        check_output("rst_after_index", btb_index, 9'h1C3);
        check_output("rst_after_din", btb_din, 129'hABC);
        next_cycle();
        check_output("rst_after_empty", upd_count, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
